// File: rtl/fib_scan_ctrl.sv
// Sequencer that walks a packed BCD word one digit per clock through an external
// combinational Fibonacci-digit recognizer and gathers per-digit hits and a hit count.
module fib_scan_ctrl #(
    parameter int unsigned N_DIGITS = 4,
    localparam int unsigned CNT_W = $clog2(N_DIGITS + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [4*N_DIGITS-1:0] bcd_word,
    output logic [3:0]            rec_bcd,
    input  logic                  rec_f,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      hit_count,
    output logic [N_DIGITS-1:0]   hit_mask,
    output logic                  bad_digit
);

    localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [N_DIGITS-1:0][3:0] word_reg;
    logic [IDX_W-1:0]         idx;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start is only honoured in IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_SCAN;
            ST_SCAN: if (idx == LAST_IDX) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Digit presented to the recognizer; zero whenever no scan is in flight
    always_comb begin
        rec_bcd = 4'd0;
        if (state_q == ST_SCAN) begin
            rec_bcd = word_reg[idx];
        end
    end

    // Datapath and registered status; busy/done follow the next state so they
    // line up with the state they describe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_reg  <= '0;
            idx       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            hit_count <= '0;
            hit_mask  <= '0;
            bad_digit <= 1'b0;
        end else begin
            busy <= (state_d != ST_IDLE);
            done <= (state_d == ST_DONE);
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        word_reg  <= bcd_word;
                        idx       <= '0;
                        hit_count <= '0;
                        hit_mask  <= '0;
                        bad_digit <= 1'b0;
                    end
                end
                ST_SCAN: begin
                    // Non-BCD digits never count as hits, whatever the recognizer says
                    if (rec_bcd <= 4'd9) begin
                        hit_mask[idx] <= rec_f;
                        hit_count     <= hit_count + CNT_W'(rec_f);
                    end else begin
                        hit_mask[idx] <= 1'b0;
                        bad_digit     <= 1'b1;
                    end
                    if (idx != LAST_IDX) begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fib_scan_ctrl.sv
// Self-checking bench for fib_scan_ctrl with a 4-bit Fibonacci recognizer on rec_bcd/rec_f.
module tb_fib_scan_ctrl;

    localparam int unsigned N  = 4;
    localparam int unsigned CW = $clog2(N + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [15:0]   bcd_word;
    logic [3:0]    rec_bcd;
    logic          rec_f;
    logic          busy;
    logic          done;
    logic [CW-1:0] hit_count;
    logic [N-1:0]  hit_mask;
    logic          bad_digit;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Recognizer over the full 4-bit range (13 is Fibonacci too; the DUT must ignore it)
    always_comb rec_f = (rec_bcd == 4'd0) || (rec_bcd == 4'd1) || (rec_bcd == 4'd2) ||
                        (rec_bcd == 4'd3) || (rec_bcd == 4'd5) || (rec_bcd == 4'd8) ||
                        (rec_bcd == 4'd13);

    fib_scan_ctrl #(.N_DIGITS(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bcd_word  (bcd_word),
        .rec_bcd   (rec_bcd),
        .rec_f     (rec_f),
        .busy      (busy),
        .done      (done),
        .hit_count (hit_count),
        .hit_mask  (hit_mask),
        .bad_digit (bad_digit)
    );

    function automatic void model(input logic [15:0] w, output logic [3:0] m,
                                  output int c, output logic b);
        m = 4'd0;
        c = 0;
        b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            int d;
            d = int'((w >> (4 * i)) & 16'hF);
            if (d > 9) b = 1'b1;
            else if (d == 0 || d == 1 || d == 2 || d == 3 || d == 5 || d == 8) begin
                m[i] = 1'b1;
                c++;
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a one-cycle start and wait (bounded) for done; bcd_word is scrambled after
    // the accepting edge. Returns latency, observed digit sequence and busy coverage.
    task automatic do_scan(input logic [15:0] w, output int lat, output logic [15:0] seen,
                           output logic busy_ok);
        bcd_word = w;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        bcd_word = 16'($urandom);
        busy_ok  = busy;
        lat      = -1;
        seen     = 16'd0;
        for (int k = 1; k <= 20; k++) begin
            if (k <= 4) seen[4*(k-1) +: 4] = rec_bcd;
            if (!busy) busy_ok = 1'b0;
            tick();
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic check_scan(input string name, input logic [15:0] w);
        int lat; logic [15:0] seen; logic bok;
        logic [3:0] em; int ec; logic eb;
        model(w, em, ec, eb);
        do_scan(w, lat, seen, bok);
        total++; if (lat !== 4) begin bad++; $display("FAIL %s latency got=%0d exp=4", name, lat); end
        total++; if (seen !== w) begin bad++; $display("FAIL %s rec_bcd seq got=%h exp=%h", name, seen, w); end
        total++; if (bok !== 1'b1) begin bad++; $display("FAIL %s busy during scan got=%b exp=1", name, bok); end
        total++; if (hit_mask !== em) begin bad++; $display("FAIL %s hit_mask got=%b exp=%b", name, hit_mask, em); end
        total++; if (hit_count !== CW'(ec)) begin bad++; $display("FAIL %s hit_count got=%0d exp=%0d", name, hit_count, ec); end
        total++; if (bad_digit !== eb) begin bad++; $display("FAIL %s bad_digit got=%b exp=%b", name, bad_digit, eb); end
        tick();
        total++; if ({done, busy} !== 2'b00) begin bad++; $display("FAIL %s done/busy after done got=%b exp=00", name, {done, busy}); end
        total++; if (hit_mask !== em || hit_count !== CW'(ec)) begin
            bad++; $display("FAIL %s result hold got=%b/%0d exp=%b/%0d", name, hit_mask, hit_count, em, ec);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; bcd_word = 16'h0;
        tick(); tick();
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            total++;
            if ({busy, done, hit_count, hit_mask, bad_digit, rec_bcd} !== '0) begin
                bad++;
                $display("FAIL reset_idle cyc%0d got busy=%b done=%b cnt=%0d mask=%b bad=%b rec=%0d exp all 0",
                         c, busy, done, hit_count, hit_mask, bad_digit, rec_bcd);
            end
        end
    endtask

    task automatic test_patterns();
        check_scan("all_fib_5813", 16'h5813);
        check_scan("no_fib_4796", 16'h4796);
        check_scan("bad_0A21", 16'h0A21);
        check_scan("bad_D0F8", 16'hD0F8);
    endtask

    task automatic test_ignore_start();
        int ndone = 0;
        bcd_word = 16'h0000; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        bcd_word = 16'h4444; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (done) ndone++;
            tick();
        end
        total++; if (ndone !== 1) begin bad++; $display("FAIL ignore_start done pulses got=%0d exp=1", ndone); end
        total++; if (hit_mask !== 4'b1111 || hit_count !== CW'(4) || bad_digit !== 1'b0) begin
            bad++; $display("FAIL ignore_start result got=%b/%0d/%b exp=1111/4/0", hit_mask, hit_count, bad_digit);
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ignore_start idle busy got=%b exp=0", busy); end
    endtask

    task automatic test_back_to_back();
        int times[$];
        bcd_word = 16'h0003; start = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (done) begin
                times.push_back(c);
                total++;
                if (hit_mask !== 4'b1111 || hit_count !== CW'(4)) begin
                    bad++; $display("FAIL b2b result at cyc%0d got=%b/%0d exp=1111/4", c, hit_mask, hit_count);
                end
            end
        end
        start = 1'b0;
        for (int c = 0; c < 8; c++) tick();
        total++; if (times.size() !== 3) begin bad++; $display("FAIL b2b pulse count got=%0d exp=3", times.size()); end
        for (int i = 0; i < times.size(); i++) begin
            total++;
            if (times[i] !== 5 + 6 * i) begin bad++; $display("FAIL b2b pulse%0d cycle got=%0d exp=%0d", i, times[i], 5 + 6 * i); end
        end
    endtask

    task automatic test_reset_mid_scan();
        int ndone = 0;
        bcd_word = 16'h5813; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        reset = 1'b1;
        #1;
        total++;
        if ({busy, done, hit_count, hit_mask, bad_digit, rec_bcd} !== '0) begin
            bad++;
            $display("FAIL async_reset got busy=%b done=%b cnt=%0d mask=%b bad=%b rec=%0d exp all 0",
                     busy, done, hit_count, hit_mask, bad_digit, rec_bcd);
        end
        tick();
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (done || busy) ndone++;
        end
        total++; if (ndone !== 0) begin bad++; $display("FAIL reset_no_done activity cycles got=%0d exp=0", ndone); end
        check_scan("after_reset_5813", 16'h5813);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            logic [15:0] w;
            for (int d = 0; d < 4; d++) w[4*d +: 4] = 4'($urandom_range(0, 15));
            check_scan($sformatf("rand%0d_%h", i, w), w);
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_patterns();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_scan();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fib_scan_ctrl.md
Name: fib_scan_ctrl

Overview:
Sequencer that time-shares one combinational fib_rec recognizer across a multi-digit packed BCD word. On start, it presents one digit per clock to the recognizer, least-significant digit first. It collects per-digit hit flags and a hit count, then pulses done. It sits between a BCD source (switch/register front end) and the display logic, with fib_rec instantiated alongside it.

Parameters:
N_DIGITS, 4, number of BCD digits in the input word (legal range 1..8)
CNT_W, $clog2(N_DIGITS+1), width of hit_count (derived; not overridden)

Ports:
clk  input  1  system clock, rising-edge active
reset  input  1  asynchronous, active-high reset
start  input  1  request a scan; sampled only in IDLE
bcd_word  input  4*N_DIGITS  packed BCD word; digit i is bits [4i+3:4i]
rec_bcd  output  4  digit driven to fib_rec BCD_in
rec_f  input  1  fib_rec f output for rec_bcd
busy  output  1  high in SCAN and DONE
done  output  1  one-cycle pulse when results are valid
hit_count  output  CNT_W  number of Fibonacci digits found
hit_mask  output  N_DIGITS  bit i = digit i is a Fibonacci number
bad_digit  output  1  at least one digit > 9 in the last scan

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. Ports are named clk and reset.
- Reset values: state=IDLE, idx=0, word register=0, rec_bcd=0, busy=0, done=0, hit_count=0, hit_mask=0, bad_digit=0.
- FSM states: IDLE, SCAN, DONE.
- IDLE -> SCAN when start=1 at a clock edge:
  - latch bcd_word into the internal word register;
  - set idx=0;
  - clear hit_count, hit_mask and bad_digit.
  - start=0 keeps the FSM in IDLE, and the previous results stay held on the outputs.
- rec_bcd is combinational:
  - in SCAN, rec_bcd = word_reg[4*idx+3:4*idx];
  - in IDLE and DONE, rec_bcd = 0.
- Each SCAN edge (digit d = current rec_bcd):
  - if d <= 9: hit_mask[idx] <= rec_f and hit_count <= hit_count + rec_f;
  - if d > 9: hit_mask[idx] <= 0, hit_count unchanged, bad_digit <= 1. rec_f is ignored for that digit.
  - if idx == N_DIGITS-1, go to DONE; otherwise idx <= idx+1.
- DONE: done=1 for exactly one cycle, then unconditional return to IDLE. Results hold until the next accepted start.
- Latency: start sampled at edge E0 -> digits sampled at edges E1..EN -> done high between EN and EN+1. busy is high from E0 to EN+1, i.e. N_DIGITS+1 cycles.
- Input stability: start in SCAN or DONE is ignored, with no queuing. bcd_word changes after E0 have no effect.
- Back-to-back: start held high continuously gives a new scan every N_DIGITS+2 cycles.
- Reset mid-scan: reset asserted in any state returns the block immediately to reset values. The partial results are discarded and no done pulse is produced.
- Arithmetic: hit_count never exceeds N_DIGITS, and CNT_W guarantees no overflow.
- Recognizer contract: rec_f=1 exactly for digit values {0,1,2,3,5,8}. rec_f is only consumed for digit values 0..9.
- idx width is $clog2(N_DIGITS), minimum 1 bit. The N_DIGITS=1 case must pass through SCAN exactly once.

Test Plan:
- Bench setup: N_DIGITS=4, real fib_rec connected, clk period 10 ns.
- Reset, then idle 3 cycles -> all outputs 0 and rec_bcd=0; no done pulse.
- bcd_word=16'h5813, 1-cycle start -> rec_bcd sequence 3,1,8,5 on 4 consecutive cycles. done pulses exactly 4 cycles after the start edge, with hit_mask=4'b1111, hit_count=4, bad_digit=0.
- bcd_word=16'h4796 -> hit_mask=4'b0000, hit_count=0, bad_digit=0. Then bcd_word=16'h0A21 -> hit_mask=4'b1011, hit_count=3, bad_digit=1.
- bcd_word=16'h0000; change bcd_word to 16'h4444 and pulse start again during SCAN -> that start is ignored and the result is mask 4'b1111, count 4. Exactly one done pulse occurs, and results hold through the following IDLE cycles.
- Start held high 20 cycles with bcd_word=16'h0003 -> done pulses every 6 cycles, each with hit_mask=4'b1111, hit_count=4.
- Assert reset 2 cycles after start on 16'h5813, release, then wait 10 cycles -> outputs return to 0 asynchronously (checked before the next clock edge), no done pulse, and a fresh start then completes normally.
